multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of cycles that mem_req may wait for mem_ready.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  7  inst[6:0] from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  shared instruction/data memory access complete this cycle.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_we  output  1  memory write (sw data phase only).
REQ-009 iord  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-010 ir_write  output  1  load the instruction register.
REQ-011 pc_write  output  1  update the PC.
REQ-012 pc_src  output  1  PC source: 0 = PC+4, 1 = branch target.
REQ-013 alusrc  output  1  ALU B operand: 0 = register, 1 = ImmGen.
REQ-014 aluop  output  2  0 = add, 1 = sub, 2 = funct decode.
REQ-015 regwrite  output  1  register bank write enable.
REQ-016 memtoreg  output  1  writeback source: 1 = memory read data.
REQ-017 retire  output  1  one-cycle pulse when an instruction completes.
REQ-018 error  output  1  sticky flag: illegal opcode or memory timeout.
REQ-019 instr_count  output  32  count of retired instructions.
REQ-020 state  output  3  current FSM state, for debug.

Function
REQ-021 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7.
REQ-022 Outputs SHALL be combinational from the current state and the latched opcode; every output not listed for a state is 0.
REQ-023 FETCH: mem_req=1, iord=0; wait while mem_ready=0; in the mem_ready cycle assert ir_write=1, pc_write=1 and pc_src=0, then go to DECODE.
REQ-024 DECODE: latch opcode internally. The next state SHALL be:
- 0110011 (R), 0010011 (addi), 0000011 (lw), 0100011 (sw), 1100011 (beq): EXEC.
- 0000000 (nop): FETCH, with retire=1.
- any other opcode: ERROR.
REQ-025 EXEC by latched opcode:
- R: aluop=2; next WB.
- addi: alusrc=1, aluop=0; next WB.
- lw/sw: alusrc=1, aluop=0; next MEM.
- beq: aluop=1, pc_src=1, pc_write=zero, retire=1; next FETCH.
REQ-026 MEM: mem_req=1, iord=1, alusrc=1, mem_we=1 for sw only; wait for mem_ready; in the mem_ready cycle sw asserts retire=1 and goes to FETCH, lw goes to WB.
REQ-027 WB: regwrite=1, memtoreg=1 for lw (0 otherwise), retire=1; next FETCH.
REQ-028 Minimum latency with mem_ready tied to 1: beq 3 cycles, R/addi/sw 4 cycles, lw 5 cycles, nop 2 cycles.
REQ-029 A wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle with mem_req=1 and mem_ready=0.
REQ-030 If the wait counter reaches TIMEOUT, the FSM SHALL go to ERROR on the next edge.
REQ-031 A mem_ready arriving in the same cycle the counter reaches TIMEOUT SHALL win: the access completes normally.
REQ-032 ERROR: all control outputs 0, error=1; the FSM remains in ERROR until reset.
REQ-033 mem_ready SHALL be ignored in DECODE, EXEC, WB and ERROR.
REQ-034 instr_count SHALL increment by 1 on each retire cycle and wrap from 0xFFFFFFFF to 0.
REQ-035 mem_req SHALL remain asserted continuously from the start of an access until its mem_ready cycle.

Reset
REQ-036 When rst=0, the block SHALL asynchronously force: state=FETCH, instr_count=0, error=0, wait counter=0, latched opcode=0.
REQ-037 After the first rising clk edge with rst=1, the block SHALL issue a FETCH request (mem_req=1, iord=0).
REQ-038 Reset asserted mid-instruction (for example in MEM with mem_we=1) SHALL drop mem_req and mem_we in the same cycle, with no retire.

Verification
REQ-039 mem_ready=1 always, program addi(0x13), add(0x33), sw(0x23), lw(0x03) -> state sequences 0,1,2,4 / 0,1,2,4 / 0,1,2,3 / 0,1,2,3,4; instr_count=4 after 17 cycles.
REQ-040 beq (0x63) with zero=1 then zero=0 -> in EXEC, pc_write=1,pc_src=1 the first time and pc_write=0,pc_src=1 the second time; retire=1 both times.
REQ-041 lw with mem_ready delayed 3 cycles in MEM -> mem_req=1,iord=1 held for 4 cycles, then WB with regwrite=1 and memtoreg=1.
REQ-042 TIMEOUT=15 with mem_ready stuck at 0 in FETCH -> ERROR (state=7, error=1) after 15 waiting cycles; mem_ready in the 15th waiting cycle instead -> DECODE.
REQ-043 Opcode 0x7F -> DECODE then ERROR; the FSM stays in ERROR until rst=0, after which state=0 and error=0 asynchronously.
REQ-044 nop (0x00) stream -> 2-cycle retire cadence; preload instr_count to 0xFFFFFFFF by forcing it in the bench, then one nop -> instr_count wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RISC-V-style datapath sharing one memory for
// instructions and data. Bounds every memory wait and latches a sticky error.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        retire,
  output logic        error,
  output logic [31:0] instr_count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [6:0]      op_q;
  logic [CW-1:0]   wait_q;
  logic            run_q;
  logic            error_q;
  logic [31:0]     count_q;
  logic            timeout;

  // run_q holds every output low until the first edge after reset releases,
  // so an aborted access drops mem_req/mem_we the moment rst falls.
  always_comb begin
    // NOTE: every output and next-state gets a default first so no path
    // through the case statement can leave a latch behind.
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = 1'b0;
    alusrc   = 1'b0;
    aluop    = 2'd0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    retire   = 1'b0;
    timeout  = (wait_q == CW'(TIMEOUT - 1));

    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (timeout) begin
            state_d = S_ERROR;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
            OP_NOP: begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            default: state_d = S_ERROR;
          endcase
        end
        S_EXEC: begin
          case (op_q)
            OP_R: begin
              aluop   = 2'd2;
              state_d = S_WB;
            end
            OP_ADDI: begin
              alusrc  = 1'b1;
              state_d = S_WB;
            end
            OP_LW, OP_SW: begin
              alusrc  = 1'b1;
              state_d = S_MEM;
            end
            OP_BEQ: begin
              aluop    = 2'd1;
              pc_src   = 1'b1;
              pc_write = zero;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end
            default: state_d = S_ERROR;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          alusrc  = 1'b1;
          mem_we  = (op_q == OP_SW);
          if (mem_ready) begin
            if (op_q == OP_SW) begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (timeout) begin
            state_d = S_ERROR;
          end
        end
        S_WB: begin
          regwrite = 1'b1;
          memtoreg = (op_q == OP_LW);
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = S_ERROR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      run_q   <= 1'b0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      run_q   <= 1'b1;
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      // Any state change clears the wait count, covering entry to FETCH and MEM.
      if (state_d != state_q)          wait_q <= '0;
      else if (mem_req && !mem_ready)  wait_q <= wait_q + CW'(1);
      if (state_d == S_ERROR) error_q <= 1'b1;
      if (retire)             count_q <= count_q + 32'd1;
    end
  end

  assign error       = error_q;
  assign instr_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues the expected trace of
// each instruction, a negedge monitor checks it on every retire or error entry.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc;
  logic [1:0]  aluop;
  logic        regwrite, memtoreg, retire, error;
  logic [31:0] instr_count;
  logic [2:0]  state;

  multicycle_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alusrc(alusrc), .aluop(aluop),
    .regwrite(regwrite), .memtoreg(memtoreg), .retire(retire), .error(error),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] trace;     // one octal digit per cycle, oldest first
    int          len;
    logic [10:0] sig;       // control outputs in the retire/error cycle
    logic [31:0] count;
    logic        err;
    int          fetch_cyc;
    int          mem_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_count = '0;
  bit          mon_en = 1'b0;
  bit          in_err = 1'b0;
  logic [63:0] tr;
  int          tr_len, f_cyc, m_cyc;
  int          cyc, total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: builds the per-instruction state trace and checks it on completion.
  always @(negedge clk) begin
    if (!mon_en) begin
      tr = '0; tr_len = 0; f_cyc = 0; m_cyc = 0; in_err = 1'b0;
    end else if (!in_err) begin
      tr = {tr[60:0], state};
      tr_len++;
      if (mem_req && !iord) f_cyc++;
      if (mem_req && iord)  m_cyc++;
      if (retire || state == 3'd7) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_event: state %0d retire %0b with nothing queued", state, retire);
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, "_trace"}, tr, mon_e.trace);
          check({mon_e.name, "_len"}, tr_len, mon_e.len);
          check({mon_e.name, "_sig"},
                {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc, aluop, regwrite, memtoreg},
                mon_e.sig);
          check({mon_e.name, "_count"}, instr_count, mon_e.count);
          check({mon_e.name, "_error"}, error, mon_e.err);
          check({mon_e.name, "_fetch_cycles"}, f_cyc, mon_e.fetch_cyc);
          check({mon_e.name, "_mem_cycles"}, m_cyc, mon_e.mem_cyc);
        end
        if (state == 3'd7) in_err = 1'b1;
        tr = '0; tr_len = 0; f_cyc = 0; m_cyc = 0;
      end
    end
  end

  // Queues the expectation, then drives one instruction until retire or ERROR.
  // fdel/mdel: number of leading FETCH/MEM cycles with mem_ready low.
  task automatic run_instr(input string name, input logic [6:0] op, input logic z,
                           input int fdel, input int mdel,
                           input logic [63:0] etr, input int elen, input logic [10:0] esig,
                           input logic eerr, input int efc, input int emc,
                           output int cycles);
    exp_t e;
    int   fcnt, mcnt;
    bit   done;
    e.name = name; e.trace = etr; e.len = elen; e.sig = esig; e.count = exp_count;
    e.err = eerr; e.fetch_cyc = efc; e.mem_cyc = emc;
    exp_q.push_back(e);
    if (!eerr) exp_count = exp_count + 32'd1;
    fcnt = 0; mcnt = 0; cycles = 0; done = 1'b0;
    opcode = op; zero = z;
    while (!done && cycles < 64) begin
      if (state == 3'd0) begin
        mem_ready = (fcnt >= fdel); fcnt++;
      end else if (state == 3'd3) begin
        mem_ready = (mcnt >= mdel); mcnt++;
      end else begin
        mem_ready = 1'b1;
      end
      @(negedge clk);
      done = retire || (state == 3'd7);
      cycles++;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no retire or error within 64 cycles", name);
    end
  endtask

  // Asserts reset between edges, checks the asynchronous effect, then restarts.
  task automatic apply_reset(input string tag);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check({tag, "_state"}, state, 3'd0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_req_we_retire"}, {mem_req, mem_we, retire}, 3'b000);
    check({tag, "_count"}, instr_count, 32'd0);
    exp_count = '0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check({tag, "_first_fetch"}, {mem_req, iord}, 2'b10);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    apply_reset("reset");

    // Straight-line program with mem_ready always high: 4+4+4+5 cycles.
    total = 0;
    run_instr("addi", 7'h13, 1'b0, 0, 0, 64'o0124, 4, 11'b000_000_0_00_10, 1'b0, 1, 0, cyc); total += cyc;
    run_instr("add",  7'h33, 1'b0, 0, 0, 64'o0124, 4, 11'b000_000_0_00_10, 1'b0, 1, 0, cyc); total += cyc;
    run_instr("sw",   7'h23, 1'b0, 0, 0, 64'o0123, 4, 11'b111_000_1_00_00, 1'b0, 1, 1, cyc); total += cyc;
    run_instr("lw",   7'h03, 1'b0, 0, 0, 64'o01234, 5, 11'b000_000_0_00_11, 1'b0, 1, 1, cyc); total += cyc;
    check("prog_cycles", total, 17);
    check("prog_count", instr_count, 32'd4);

    run_instr("beq_taken",     7'h63, 1'b1, 0, 0, 64'o012, 3, 11'b000_011_0_01_00, 1'b0, 1, 0, cyc);
    check("beq_cycles", cyc, 3);
    run_instr("beq_not_taken", 7'h63, 1'b0, 0, 0, 64'o012, 3, 11'b000_001_0_01_00, 1'b0, 1, 0, cyc);

    run_instr("lw_slow", 7'h03, 1'b0, 0, 3, 64'o01233334, 8, 11'b000_000_0_00_11, 1'b0, 1, 4, cyc);

    for (int i = 0; i < 3; i++) begin
      run_instr("nop", 7'h00, 1'b0, 0, 0, 64'o01, 2, 11'b0, 1'b0, 1, 0, cyc);
      check("nop_cycles", cyc, 2);
    end

    // mem_ready arrives in the 15th waiting FETCH cycle: access completes.
    run_instr("fetch_edge", 7'h13, 1'b0, 14, 0, 64'o124, 18, 11'b000_000_0_00_10, 1'b0, 15, 0, cyc);
    check("count_before_wrap", instr_count, 32'd11);

    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    exp_count = 32'hFFFF_FFFF;
    run_instr("nop_wrap", 7'h00, 1'b0, 0, 0, 64'o01, 2, 11'b0, 1'b0, 1, 0, cyc);
    check("count_wrapped", instr_count, 32'd0);

    // mem_ready never arrives: 15 waiting cycles then ERROR.
    run_instr("fetch_timeout", 7'h00, 1'b0, 99, 0, 64'o7, 16, 11'b0, 1'b1, 15, 0, cyc);
    mem_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("timeout_stays_error", {state, error}, {3'd7, 1'b1});
    apply_reset("clear_timeout");

    run_instr("illegal", 7'h7F, 1'b0, 0, 0, 64'o017, 3, 11'b0, 1'b1, 1, 0, cyc);
    repeat (4) @(posedge clk);
    #1;
    check("illegal_stays_error", {state, error, mem_req}, {3'd7, 1'b1, 1'b0});
    apply_reset("clear_illegal");

    // Abort a store in its MEM phase.
    opcode = 7'h23;
    cyc = 0;
    while (state != 3'd3 && cyc < 20) begin
      mem_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("abort_in_mem", {state, mem_req, mem_we, iord}, {3'd3, 3'b111});
    @(posedge clk); #1;
    apply_reset("abort");

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
